// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO array and its skewed reader.
package fifo_pkg;

  // Default geometry, shared with fifo_array.
  localparam int DEF_DATA_SIZE  = 8;
  localparam int DEF_ARRAY_SIZE = 9;
  localparam int DEF_LOG_DEPTH  = 12;

  // Reader sequencing states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/skew_lane_reg.sv
// One reader lane: decides whether this lane is inside its diagonal window
// and registers the read strobe so the PE sees data the cycle after r_en.
module skew_lane_reg #(
  parameter int LANE      = 0,
  parameter int DATA_SIZE = 8,
  parameter int CW        = 13
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_run,
  input  logic [CW-1:0]        i_t,
  input  logic [CW-1:0]        i_len,
  input  logic                 i_r_en,
  input  logic [DATA_SIZE-1:0] i_fifo_lane,
  output logic                 o_active,
  output logic [DATA_SIZE-1:0] o_pe_data,
  output logic                 o_pe_valid
);

  localparam logic [CW-1:0] LANE_C = CW'(LANE);

  logic          w_started;
  logic [CW-1:0] w_lane_end;
  logic          r_valid;

  // Lane 0 starts at t=0, so its lower bound is always met.
  if (LANE == 0) begin : g_first
    assign w_started = 1'b1;
  end else begin : g_other
    assign w_started = (i_t >= LANE_C);
  end

  assign w_lane_end = LANE_C + i_len;

  // Lane window: LANE <= t < LANE + len, only while the wavefront runs.
  always_comb begin
    o_active = i_run && w_started && (i_t < w_lane_end);
  end

  // A pop issued this cycle turns into valid PE data next cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= i_r_en;
    end
  end

  // The FIFO presents popped data the cycle after r_en; gate it so a
  // bubble lane always reads as zero.
  always_comb begin
    o_pe_valid = r_valid;
    o_pe_data  = r_valid ? i_fifo_lane : '0;
  end

endmodule

// File: rtl/fifo_skew_reader.sv
// Pops the FIFO array lanes in wavefront order (lane i lags lane 0 by i
// cycles) and stalls the whole wavefront when any needed lane is empty.
//
// Handshake: a lane is popped only when fifo_r_en[i]=1; that happens only
// when every active lane is non-empty (all-or-nothing). pe_valid[i]=1 marks
// the cycle carrying that popped element; pe_valid=0 is a bubble.
module fifo_skew_reader
  import fifo_pkg::*;
#(
  parameter int DATA_SIZE  = DEF_DATA_SIZE,
  parameter int ARRAY_SIZE = DEF_ARRAY_SIZE,
  parameter int LOG_DEPTH  = DEF_LOG_DEPTH
) (
  input  logic                            r_clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [LOG_DEPTH:0]              vec_len,
  input  logic [DATA_SIZE*ARRAY_SIZE-1:0] fifo_data,
  input  logic [ARRAY_SIZE-1:0]           fifo_empty,
  output logic [ARRAY_SIZE-1:0]           fifo_r_en,
  output logic [DATA_SIZE*ARRAY_SIZE-1:0] pe_data,
  output logic [ARRAY_SIZE-1:0]           pe_valid,
  output logic                            stall,
  output logic                            busy,
  output logic                            done,
  output logic [1:0]                      dbg_state
);

  localparam int CW = LOG_DEPTH + 1;
  localparam logic [CW-1:0] TAIL = CW'(ARRAY_SIZE - 2);

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_t;
  logic [CW-1:0]   r_len;
  logic            w_run;
  logic            w_stall;
  logic            w_last;
  logic [ARRAY_SIZE-1:0] w_active;
  logic [ARRAY_SIZE-1:0] w_r_en;

  assign w_run  = (r_state == RUN);
  assign w_last = (r_t == (r_len + TAIL));

  // Per-lane window compare and PE output register.
  for (genvar g = 0; g < ARRAY_SIZE; g++) begin : g_lane
    skew_lane_reg #(
      .LANE      (g),
      .DATA_SIZE (DATA_SIZE),
      .CW        (CW)
    ) u_lane (
      .i_clk       (r_clk),
      .i_rst_n     (rst_n),
      .i_run       (w_run),
      .i_t         (r_t),
      .i_len       (r_len),
      .i_r_en      (w_r_en[g]),
      .i_fifo_lane (fifo_data[g*DATA_SIZE +: DATA_SIZE]),
      .o_active    (w_active[g]),
      .o_pe_data   (pe_data[g*DATA_SIZE +: DATA_SIZE]),
      .o_pe_valid  (pe_valid[g])
    );
  end

  // Stall if any lane that needs data is empty; then nobody pops.
  always_comb begin
    w_stall = w_run && (|(w_active & fifo_empty));
    w_r_en  = w_stall ? '0 : w_active;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_next = (vec_len != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (!w_stall && w_last) begin
          w_next = DRAIN;
        end
      end
      DRAIN:   w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge r_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Wavefront counter and latched length; t freezes while stalled.
  always_ff @(posedge r_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_t   <= '0;
      r_len <= '0;
    end else if ((r_state == IDLE) && start && (vec_len != '0)) begin
      r_t   <= '0;
      r_len <= vec_len;
    end else if (w_run && !w_stall) begin
      r_t <= r_t + 1'b1;
    end
  end

  // Status outputs.
  always_comb begin
    fifo_r_en = w_r_en;
    stall     = w_stall;
    busy      = (r_state == RUN) || (r_state == DRAIN);
    done      = (r_state == DONE);
    dbg_state = r_state;
  end

endmodule
